// File: rtl/misc_v_ctrl_pkg.sv
// misc_v_ctrl_pkg: shared state, opcode, ALUop and RegStore encodings for the MISC-V control path.
`default_nettype none

package misc_v_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_I    = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BNE  = 3'd5;
  localparam logic [2:0] OP_JIN  = 3'd6;
  localparam logic [2:0] OP_JOUT = 3'd7;

  localparam int ALU_NONE = 0;
  localparam int ALU_ADD  = 1;
  localparam int ALU_SUB  = 2;
  localparam int ALU_AND  = 3;
  localparam int ALU_OR   = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SLL  = 6;
  localparam int ALU_SRL  = 7;

  localparam logic [2:0] RS_MEM  = 3'd0;
  localparam logic [2:0] RS_ALU  = 3'd1;
  localparam logic [2:0] RS_LINK = 3'd2;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode/func to the ALU operation code and flags unsupported func values.
`default_nettype none

module alu_op_decode
  import misc_v_ctrl_pkg::*;
#(
  parameter int FUNC_W  = 4,
  parameter int ALUOP_W = 3
) (
  input  logic [2:0]         opcode,
  input  logic [FUNC_W-1:0]  func,
  output logic [ALUOP_W-1:0] aluop,
  output logic               func_legal
);

  always_comb begin
    aluop      = '0;
    func_legal = 1'b1;
    case (opcode)
      OP_R: begin
        func_legal = (func <= FUNC_W'(3));
        case (func[1:0])
          2'd0: aluop = ALUOP_W'(ALU_ADD);
          2'd1: aluop = ALUOP_W'(ALU_SUB);
          2'd2: aluop = ALUOP_W'(ALU_AND);
          2'd3: aluop = ALUOP_W'(ALU_OR);
          default: aluop = '0;
        endcase
      end
      OP_I: begin
        func_legal = (func <= FUNC_W'(3));
        case (func[1:0])
          2'd0: aluop = ALUOP_W'(ALU_ADD);
          2'd1: aluop = ALUOP_W'(ALU_XOR);
          2'd2: aluop = ALUOP_W'(ALU_SLL);
          2'd3: aluop = ALUOP_W'(ALU_SRL);
          default: aluop = '0;
        endcase
      end
      OP_LW, OP_SW:   aluop = ALUOP_W'(ALU_ADD);
      OP_BEQ, OP_BNE: aluop = ALUOP_W'(ALU_SUB);
      default:        aluop = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with registered Moore outputs.
`default_nettype none

module multicycle_control
  import misc_v_ctrl_pkg::*;
#(
  parameter int FUNC_W      = 4,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [2:0]         opcode,
  input  logic [FUNC_W-1:0]  func,
  input  logic               mem_ready,
  output logic               RegWrite,
  output logic               ALUsrc,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               Branch,
  output logic               JumpOut,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         RegStore,
  output logic               IRWrite,
  output logic               busy,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t             state;
  logic [2:0]         op_reg;
  logic [FUNC_W-1:0]  func_reg;
  logic [CNT_W-1:0]   wait_cnt;
  logic [2:0]         dec_op;
  logic [FUNC_W-1:0]  dec_func;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_legal;
  logic               timeout_hit;

  // In FETCH the decoder looks at the live inputs so DECODE's illegal flag can be registered on capture.
  assign dec_op   = (state == FETCH) ? opcode : op_reg;
  assign dec_func = (state == FETCH) ? func   : func_reg;

  alu_op_decode #(
    .FUNC_W  (FUNC_W),
    .ALUOP_W (ALUOP_W)
  ) u_alu_op_decode (
    .opcode     (dec_op),
    .func       (dec_func),
    .aluop      (dec_aluop),
    .func_legal (dec_legal)
  );

  // Fires on the MEM cycle whose mem_ready=0 would be the MEM_TIMEOUT-th such cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((int'(wait_cnt) + 1) >= MEM_TIMEOUT);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= FETCH;
      op_reg     <= '0;
      func_reg   <= '0;
      wait_cnt   <= '0;
      RegWrite   <= 1'b0;
      ALUsrc     <= 1'b0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      Branch     <= 1'b0;
      JumpOut    <= 1'b0;
      ALUop      <= '0;
      RegStore   <= RS_MEM;
      IRWrite    <= 1'b0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      RegWrite   <= 1'b0;
      ALUsrc     <= 1'b0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      Branch     <= 1'b0;
      JumpOut    <= 1'b0;
      ALUop      <= '0;
      RegStore   <= RS_MEM;
      IRWrite    <= 1'b0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      mem_fault  <= 1'b0;
      wait_cnt   <= '0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            state    <= DECODE;
            op_reg   <= opcode;
            func_reg <= func;
            IRWrite  <= 1'b1;
            busy     <= 1'b1;
            illegal  <= !dec_legal;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            state  <= EXECUTE;
            busy   <= 1'b1;
            ALUop  <= dec_aluop;
            ALUsrc <= (op_reg == OP_R);
            case (op_reg)
              OP_BEQ, OP_BNE: begin
                Branch     <= 1'b1;
                instr_done <= 1'b1;
              end
              OP_JIN: begin
                Branch   <= 1'b1;
                RegStore <= RS_LINK;
              end
              OP_JOUT: begin
                Branch     <= 1'b1;
                JumpOut    <= 1'b1;
                instr_done <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            state <= FETCH;
          end
        end
        EXECUTE: begin
          case (op_reg)
            OP_R, OP_I, OP_JIN: begin
              state      <= WRITEBACK;
              busy       <= 1'b1;
              RegWrite   <= 1'b1;
              instr_done <= 1'b1;
              ALUop      <= ALUop;
              ALUsrc     <= ALUsrc;
              RegStore   <= (op_reg == OP_JIN) ? RS_LINK : RS_ALU;
            end
            OP_LW, OP_SW: begin
              state    <= MEM;
              busy     <= 1'b1;
              ALUop    <= ALUOP_W'(ALU_ADD);
              MemRead  <= (op_reg == OP_LW);
              MemWrite <= (op_reg == OP_SW);
            end
            default: state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op_reg == OP_LW) begin
              state      <= WRITEBACK;
              busy       <= 1'b1;
              RegWrite   <= 1'b1;
              instr_done <= 1'b1;
              RegStore   <= RS_MEM;
              ALUop      <= ALUOP_W'(ALU_ADD);
            end else begin
              state      <= FETCH;
              instr_done <= 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= FETCH;
            mem_fault <= 1'b1;
          end else begin
            busy     <= 1'b1;
            ALUop    <= ALUOP_W'(ALU_ADD);
            MemRead  <= MemRead;
            MemWrite <= MemWrite;
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with a per-cycle expected-output scoreboard.
`default_nettype none

module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [3:0] func = 4'd0;
  logic       mem_ready = 1'b0;
  logic       RegWrite, ALUsrc, MemWrite, MemRead, Branch, JumpOut;
  logic [2:0] ALUop;
  logic [2:0] RegStore;
  logic       IRWrite, busy, instr_done, illegal, mem_fault;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multicycle_control #(
    .FUNC_W      (4),
    .ALUOP_W     (3),
    .MEM_TIMEOUT (15)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .func        (func),
    .mem_ready   (mem_ready),
    .RegWrite    (RegWrite),
    .ALUsrc      (ALUsrc),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .Branch      (Branch),
    .JumpOut     (JumpOut),
    .ALUop       (ALUop),
    .RegStore    (RegStore),
    .IRWrite     (IRWrite),
    .busy        (busy),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .mem_fault   (mem_fault)
  );

  always #5 CLK = ~CLK;

  // Packing: {RegWrite,ALUsrc,MemWrite,MemRead,Branch,JumpOut,ALUop,RegStore,IRWrite,busy,instr_done,illegal,mem_fault}
  function automatic logic [16:0] ov(input bit rw, input bit asrc, input bit mw, input bit mr,
                                     input bit br, input bit jo, input int alu, input int rs,
                                     input bit irw, input bit bsy, input bit dn, input bit il,
                                     input bit ft);
    return {rw, asrc, mw, mr, br, jo, 3'(alu), 3'(rs), irw, bsy, dn, il, ft};
  endfunction

  task automatic push(input string tag, input logic [16:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input string tag, input logic [16:0] v);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    push(tag, v);
    @(posedge CLK);
    #1;
  endtask

  // Presents the instruction in cycle 0 only, then scrambles opcode/func to prove they were captured.
  task automatic issue(input logic [2:0] op, input logic [3:0] fn, input int n, input int rdy);
    for (int i = 0; i < n; i++) begin
      instr_valid = (i == 0);
      opcode      = (i == 0) ? op : ~op;
      func        = (i == 0) ? fn : ~fn;
      mem_ready   = (i == rdy);
      @(posedge CLK);
      #1;
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    exp_t        e;
    logic [16:0] act;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {RegWrite, ALUsrc, MemWrite, MemRead, Branch, JumpOut, ALUop, RegStore,
               IRWrite, busy, instr_done, illegal, mem_fault};
        n_checks++;
        if (act === e.v) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", e.tag, act, e.v);
      end
    end
  end

  initial begin
    logic [16:0] z;
    z = ov(0,0,0,0,0,0,0,0,0,0,0,0,0);

    repeat (2) @(posedge CLK);
    #1;
    push("reset", z);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    idle_cycle("post_reset_fetch", z);

    // R add
    push("r_add_F", z);
    push("r_add_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("r_add_E", ov(0,1,0,0,0,0,1,0,0,1,0,0,0));
    push("r_add_W", ov(1,1,0,0,0,0,1,1,0,1,1,0,0));
    issue(3'd0, 4'd0, 4, -1);

    // R func 3 then I func 2, back to back
    push("r_f3_F", z);
    push("r_f3_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("r_f3_E", ov(0,1,0,0,0,0,4,0,0,1,0,0,0));
    push("r_f3_W", ov(1,1,0,0,0,0,4,1,0,1,1,0,0));
    issue(3'd0, 4'd3, 4, -1);
    push("i_f2_F", z);
    push("i_f2_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("i_f2_E", ov(0,0,0,0,0,0,6,0,0,1,0,0,0));
    push("i_f2_W", ov(1,0,0,0,0,0,6,1,0,1,1,0,0));
    issue(3'd1, 4'd2, 4, -1);

    // LW, mem_ready on 4th MEM cycle
    push("lw_F", z);
    push("lw_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("lw_E", ov(0,0,0,0,0,0,1,0,0,1,0,0,0));
    for (int i = 0; i < 4; i++) push("lw_M", ov(0,0,0,1,0,0,1,0,0,1,0,0,0));
    push("lw_W", ov(1,0,0,0,0,0,1,0,0,1,1,0,0));
    issue(3'd2, 4'd0, 8, 6);

    // SW, immediate ready
    push("sw_F", z);
    push("sw_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("sw_E", ov(0,0,0,0,0,0,1,0,0,1,0,0,0));
    push("sw_M", ov(0,0,1,0,0,0,1,0,0,1,0,0,0));
    issue(3'd3, 4'd0, 4, 3);
    idle_cycle("sw_done", ov(0,0,0,0,0,0,0,0,0,0,1,0,0));

    // SW timeout: 15 MEM cycles, then fault
    push("swto_F", z);
    push("swto_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("swto_E", ov(0,0,0,0,0,0,1,0,0,1,0,0,0));
    for (int i = 0; i < 15; i++) push("swto_M", ov(0,0,1,0,0,0,1,0,0,1,0,0,0));
    issue(3'd3, 4'd0, 18, -1);
    idle_cycle("swto_fault", ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
    idle_cycle("swto_after", z);

    // SW with mem_ready on the timeout cycle: ready wins
    push("swrt_F", z);
    push("swrt_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("swrt_E", ov(0,0,0,0,0,0,1,0,0,1,0,0,0));
    for (int i = 0; i < 15; i++) push("swrt_M", ov(0,0,1,0,0,0,1,0,0,1,0,0,0));
    issue(3'd3, 4'd0, 18, 17);
    idle_cycle("swrt_done", ov(0,0,0,0,0,0,0,0,0,0,1,0,0));

    // Illegal funcs
    push("ill_i9_F", z);
    push("ill_i9_D", ov(0,0,0,0,0,0,0,0,1,1,0,1,0));
    issue(3'd1, 4'd9, 2, -1);
    idle_cycle("ill_i9_back", z);
    push("ill_r4_F", z);
    push("ill_r4_D", ov(0,0,0,0,0,0,0,0,1,1,0,1,0));
    issue(3'd0, 4'd4, 2, -1);

    // Branches
    push("beq_F", z);
    push("beq_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("beq_E", ov(0,0,0,0,1,0,2,0,0,1,1,0,0));
    issue(3'd4, 4'd0, 3, -1);
    push("bne_F", z);
    push("bne_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("bne_E", ov(0,0,0,0,1,0,2,0,0,1,1,0,0));
    issue(3'd5, 4'd7, 3, -1);

    // Jump-in / jump-out
    push("jin_F", z);
    push("jin_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("jin_E", ov(0,0,0,0,1,0,0,2,0,1,0,0,0));
    push("jin_W", ov(1,0,0,0,0,0,0,2,0,1,1,0,0));
    issue(3'd6, 4'd0, 4, -1);
    push("jout_F", z);
    push("jout_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("jout_E", ov(0,0,0,0,1,1,0,0,0,1,1,0,0));
    issue(3'd7, 4'd0, 3, -1);

    // Reset during MEM with MemWrite high
    push("rst_F", z);
    push("rst_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("rst_E", ov(0,0,0,0,0,0,1,0,0,1,0,0,0));
    push("rst_M1", ov(0,0,1,0,0,0,1,0,0,1,0,0,0));
    issue(3'd3, 4'd0, 4, -1);
    push("rst_M2", ov(0,0,1,0,0,0,1,0,0,1,0,0,0));
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    idle_cycle("rst_after1", z);
    idle_cycle("rst_after2", z);

    // Short R add after reset to confirm a clean restart
    push("r2_F", z);
    push("r2_D", ov(0,0,0,0,0,0,0,0,1,1,0,0,0));
    push("r2_E", ov(0,1,0,0,0,0,2,0,0,1,0,0,0));
    push("r2_W", ov(1,1,0,0,0,0,2,1,0,1,1,0,0));
    issue(3'd0, 4'd1, 4, -1);

    repeat (2) @(negedge CLK);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
